// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-indexed single-port data memory (byte/half/word, RMW sub-word stores).
// Build option: define LSU_MISALIGN_CHECK_EN to reject misaligned half/word requests instead of aligning them.
module lsu_mem_master #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, word_q;
    logic [1:0]  size_q;
    logic        we_q, uns_q, err_q;

    logic        accept, acc_err, misalign;
    logic [31:0] acc_addr, merged, ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign accept = req_valid && req_ready;

    always_comb begin
        acc_addr = req_addr;
        misalign = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        misalign = (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
        if (req_size == 2'b01) acc_addr[0] = 1'b0;
        else if (req_size == 2'b10) acc_addr[1:0] = 2'b00;
`endif
        acc_err = (req_size == 2'b11) || ({2'b00, req_addr[31:2]} >= MEM_WORDS_W) || misalign;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= acc_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= acc_err;
            end
            if (state_q == RD || state_q == RMW_RD) word_q <= mem_rd;
        end
    end

    // Sub-word store: splice the new lane into the word read during RMW_RD
    always_comb begin
        merged = word_q;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'b00:   merged[7:0]   = wdata_q[7:0];
                    2'b01:   merged[15:8]  = wdata_q[7:0];
                    2'b10:   merged[23:16] = wdata_q[7:0];
                    default: merged[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = word_q[7:0];
            2'b01:   ld_byte = word_q[15:8];
            2'b10:   ld_byte = word_q[23:16];
            default: ld_byte = word_q[31:24];
        endcase
        ld_half = addr_q[1] ? word_q[31:16] : word_q[15:0];
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = word_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_wd     = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (acc_err)                state_d = RESP;
                    else if (!req_we)           state_d = RD;
                    else if (req_size == 2'b10) state_d = WR;
                    else                        state_d = RMW_RD;
                end
            end
            RD:     state_d = RESP;
            RMW_RD: state_d = WR;
            WR: begin
                mem_we  = 1'b1;
                mem_wd  = merged;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_a      = {2'b00, addr_q[31:2]};
    assign resp_err   = (state_q == RESP) && err_q;
    assign resp_rdata = (state_q == RESP && !err_q && !we_q) ? ld_ext : 32'h0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized self-checking bench for lsu_mem_master against a transaction-level model and shadow memory.
// Honors LSU_MISALIGN_CHECK_EN in the model.
module tb_lsu_mem_master;
    localparam int MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;

    lsu_mem_master #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // attached memory, plus a preload port owned by the bench
    logic [31:0] mem [MEM_WORDS];
    logic        pl_en = 1'b0;
    int          pl_idx = 0;
    logic [31:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_we && mem_a < 32'(MEM_WORDS)) mem[mem_a[9:0]] <= mem_wd;
    end
    assign mem_rd = (mem_a < 32'(MEM_WORDS)) ? mem[mem_a[9:0]] : 32'h0;

    logic [31:0] ref_mem [MEM_WORDS];
    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // expectation window of the transaction in flight
    int          acc_k = -100, lat = 0, wr_cyc = -100;
    logic        e_err = 1'b0;
    logic [31:0] e_rdata = '0, e_wdata = '0, e_widx = '0;
    logic        chk_en = 1'b0;

    int          we_cnt = 0;
    logic [31:0] last_wd = '0, last_wa = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            last_wd = mem_wd;
            last_wa = mem_a;
        end
    end

    always @(negedge clk) begin : compare
        logic busy;
        if (chk_en) begin
            busy = (cyc > acc_k) && (cyc <= acc_k + lat);
            chk("req_ready", {31'b0, req_ready}, {31'b0, !busy});
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, cyc == acc_k + lat});
            chk("mem_we", {31'b0, mem_we}, {31'b0, cyc == wr_cyc});
            if (cyc == wr_cyc) begin
                chk("mem_a", mem_a, e_widx);
                chk("mem_wd", mem_wd, e_wdata);
            end else begin
                chk("mem_wd_idle", mem_wd, 32'h0);
            end
            if (cyc == acc_k + lat) begin
                chk("resp_rdata", resp_rdata, e_rdata);
                chk("resp_err", {31'b0, resp_err}, {31'b0, e_err});
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] d);
        pl_en = 1'b1; pl_idx = idx; pl_data = d;
        ref_mem[idx] = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic un,
                          input logic [31:0] ad, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int obs);
        logic [31:0] a, m, v, nw;
        logic        bad, found;
        int          idx, sh, L, wr;
        @(negedge clk); #1;
        a = ad;
        bad = (sz == 2'b11) || (ad[31:2] >= 30'(MEM_WORDS));
`ifdef LSU_MISALIGN_CHECK_EN
        if ((sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00)) bad = 1'b1;
`else
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
`endif
        idx = bad ? 0 : int'(a[31:2]);
        sh  = 8 * int'(a[1:0]);
        m   = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        e_err = bad; e_rdata = 32'h0; wr = -100;
        if (bad) L = 1;
        else if (!we) begin
            L = 2;
            v = (ref_mem[idx] >> sh) & m;
            if (!un && sz == 2'b00) v = {{24{v[7]}}, v[7:0]};
            if (!un && sz == 2'b01) v = {{16{v[15]}}, v[15:0]};
            e_rdata = v;
        end else begin
            L = (sz == 2'b10) ? 2 : 3;
            nw = (ref_mem[idx] & ~(m << sh)) | ((wd & m) << sh);
            ref_mem[idx] = nw;
            e_widx = 32'(idx); e_wdata = nw;
            wr = cyc + L - 1;
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = un;
        req_addr = ad; req_wdata = wd;
        acc_k = cyc; lat = L; wr_cyc = wr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        found = 1'b0; obs = -1; rd = 'x; er = 1'bx;
        for (int i = 1; i <= 6 && !found; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                found = 1'b1; rd = resp_rdata; er = resp_err; obs = cyc - acc_k;
            end
        end
        chk("resp_seen", {31'b0, found}, 32'h1);
        if (!bad) chk("mem_state", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [31:0] rd, keep;
        logic        er;
        int          obs, w0;
        logic [1:0]  sz;
        logic [31:0] ad;

        for (int i = 0; i < 64; i++) preload(i, $urandom);
        preload(7, 32'h0000_0020);
        preload(3, 32'h1234_80FF);
        preload(5, 32'hAABB_CCDD);
        preload(8, 32'h5555_AAAA);
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'b0, resp_err}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        w0 = we_cnt;
        do_req(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, rd, er, obs);
        chk("lw_rdata", rd, 32'h0000_0020);
        chk("lw_err", {31'b0, er}, 32'h0);
        chk("lw_lat", 32'(obs), 32'd2);
        chk("lw_no_we", 32'(we_cnt - w0), 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 32'h0C, 32'h0, rd, er, obs);
        chk("lb_signed", rd, 32'hFFFF_FFFF);
        do_req(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, rd, er, obs);
        chk("lhu", rd, 32'h0000_1234);
        do_req(1'b0, 2'b01, 1'b0, 32'h0C, 32'h0, rd, er, obs);
        chk("lh_signed", rd, 32'hFFFF_80FF);

        w0 = we_cnt;
        do_req(1'b1, 2'b00, 1'b0, 32'h15, 32'hDEAD_BE11, rd, er, obs);
        chk("sb_lat", 32'(obs), 32'd3);
        chk("sb_one_wr", 32'(we_cnt - w0), 32'h1);
        chk("sb_wa", last_wa, 32'h5);
        chk("sb_wd", last_wd, 32'hAABB_11DD);
        chk("sb_mem", mem[5], 32'hAABB_11DD);
        chk("sb_rdata", rd, 32'h0);

        w0 = we_cnt;
        do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, rd, er, obs);
        chk("range_err", {31'b0, er}, 32'h1);
        chk("range_lat", 32'(obs), 32'd1);
        chk("range_rdata", rd, 32'h0);
        do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h1234_5678, rd, er, obs);
        chk("size_err", {31'b0, er}, 32'h1);
        chk("size_lat", 32'(obs), 32'd1);
        chk("err_no_we", 32'(we_cnt - w0), 32'h0);

        do_req(1'b1, 2'b10, 1'b0, 32'h22, 32'hCAFE_F00D, rd, er, obs);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("misalign_err", {31'b0, er}, 32'h1);
        chk("misalign_mem", mem[8], 32'h5555_AAAA);
`else
        chk("misalign_err", {31'b0, er}, 32'h0);
        chk("misalign_mem", mem[8], 32'hCAFE_F00D);
`endif

        // reset while the halfword store sits in RMW_RD
        keep = mem[9];
        w0 = we_cnt;
        @(negedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_addr = 32'h26;
        req_wdata = 32'h0000_BEEF;
        acc_k = cyc; lat = 3; wr_cyc = -100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk_en = 1'b0;
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_we", {31'b0, mem_we}, 32'h0);
            chk("rst_hold_ready", {31'b0, req_ready}, 32'h1);
        end
        #1 rst = 1'b0;
        acc_k = -100; lat = 0; wr_cyc = -100;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_no_wr", 32'(we_cnt - w0), 32'h0);
        chk("rst_mem_kept", mem[9], keep);
        do_req(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, rd, er, obs);
        chk("post_rst_load", rd, keep);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 15))
                0, 1, 2, 3, 4:    sz = 2'b00;
                5, 6, 7, 8, 9:    sz = 2'b01;
                10, 11, 12, 13, 14: sz = 2'b10;
                default:          sz = 2'b11;
            endcase
            if ($urandom_range(0, 11) == 0)
                ad = $urandom_range(0, 1) ? (32'h1000 + 32'($urandom_range(0, 255))) : ($urandom | 32'h8000_0000);
            else
                ad = 32'($urandom_range(0, 255));
            do_req(1'($urandom), sz, 1'($urandom), ad, $urandom, rd, er, obs);
        end

        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the single-port data memory: word-indexed memory, combinational read, write on posedge when write-enable is high.
- Accepts one byte/halfword/word request at a time from the core over a valid/ready handshake.
- Translates the byte address to a word index.
- Performs read-modify-write for sub-word stores, and sign- or zero-extends load data before returning a one-cycle response.

Parameters:
- MEM_WORDS, 1024: number of 32-bit words in the attached memory; word index >= MEM_WORDS is out of range.

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  block can accept request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned for sub-word
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores/errors
- resp_err  out  1  qualified by resp_valid; request rejected
- mem_we  out  1  memory write enable
- mem_a  out  32  memory word index = {2'b00, addr[31:2]}
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory combinational read data

Behaviour:
- States: IDLE, RD, RMW_RD, WR, RESP. The request is accepted when req_valid && req_ready, and addr/size/we/unsigned/wdata are registered.
- Reset (async, immediate):
  - state=IDLE, all request registers 0.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_we=0, mem_a=0, mem_wd=0.
- Reset mid-operation abandons the access. mem_we drops asynchronously, so a pending WR never commits.
- mem_a is combinational from the registered address in all states.
- mem_we=1 only in WR.
- mem_wd is 0 outside WR.
- Error check at accept:
  - size==11 → error.
  - Word index >= MEM_WORDS → error.
  - Misalignment per the optional feature.
  - Error path: IDLE → RESP with resp_err=1, resp_rdata=0. No memory access is made and mem_we stays 0.
- Load: IDLE → RD (mem_rd captured at end of cycle) → RESP. resp_valid arrives 2 cycles after accept.
  - Byte lane = addr[1:0].
  - Halfword lane = addr[1].
  - Extend to 32 bits per req_unsigned. Words pass unchanged.
- Word store: IDLE → WR (mem_wd=wdata) → RESP, 2 cycles.
- Sub-word store: IDLE → RMW_RD (capture mem_rd) → WR → RESP, 3 cycles.
  - In WR, mem_wd = captured word with the target lane replaced by wdata[7:0] or wdata[15:0]. Other lanes are preserved bit-exact.
- RESP lasts one cycle and has no backpressure, then returns to IDLE. req_ready=1 in the following cycle.
- req_valid while not IDLE is ignored; the core must hold it. Back-to-back throughput is 1 request per 3 cycles (load/word store) or 4 cycles (sub-word store).

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: these requests are errors, with no memory access:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- Undefined: no misalign error. The offending low address bits are forced to 0 (halfword addr[0], word addr[1:0]) and the access proceeds aligned.
- Range and size errors are unconditional.

Test Plan:
- Preload word 7=0x00000020. Load word, addr 0x1C → resp_valid 2 cycles after accept, rdata=0x00000020, err=0, mem_we never high.
- Preload word 3=0x1234_80FF.
  - Signed byte load at 0x0C → 0xFFFFFFFF.
  - Unsigned halfword load at 0x0E → 0x00001234.
  - Signed halfword load at 0x0C → 0xFFFF80FF.
- Word 5=0xAABBCCDD; byte store 0x11 at 0x15 → exactly one WR cycle with mem_a=5, mem_wd=0xAABB11DD; memory reads back 0xAABB11DD; resp 3 cycles after accept.
- Load at word index MEM_WORDS (addr 0x1000), and a size=11 request → resp_err=1 one cycle after accept, rdata=0, mem_we stays 0.
- With LSU_MISALIGN_CHECK_EN, word store at 0x22 → err=1, memory unchanged. Without it, the same store writes word 8.
- Assert rst during RMW_RD of a halfword store → mem_we never asserted, memory unchanged, req_ready=1 after release, next load works.
